chorus_fx: RTL

Parametrised mono chorus stage for the karaoke audio path. It accepts one signed PCM sample per `in_valid`/`in_ready` handshake and writes it into an internal circular delay line. It reads a tap whose delay is swept by a triangle LFO, with optional fractional interpolation, and outputs a dry/wet crossfade with a one-cycle `out_valid` pulse. It sits between the microphone sample source and the output mixer, and runs on the 50 MHz system clock.

---
 rtl/chorus_fx.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/chorus_fx.sv
// chorus_fx -- mono chorus stage for the karaoke audio path.
//
// One signed PCM sample is accepted per in_valid/in_ready handshake and
// written into a circular delay line. A tap whose delay is swept by a
// triangle LFO is read back, optionally interpolated between two adjacent
// taps, and crossfaded with the dry sample. Each result is announced by a
// one-cycle out_valid pulse; out_data holds until the next pulse.
//
// Ports:
//   clk       system clock (single domain)
//   rst_n     asynchronous active-low reset
//   in_valid  input sample present
//   in_ready  block idle, sample accepted this cycle if in_valid
//   in_data   dry sample x (signed, DATA_W)
//   wet_gain  wet weight g, 0..256 (larger values act as 256)
//   bypass    output the dry sample; buffer/LFO/counters still advance
//   out_valid one-cycle pulse marking a new out_data
//   out_data  output sample (signed, DATA_W)
//
// Build option: define CHORUS_INTERP_EN to add the TAPB state and linear
// interpolation between delays d and d+1 (latency 4, one sample per 5
// cycles). Undefined: nearest-lower integer delay (latency 3, 1 per 4).

module chorus_fx #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int BASE_DELAY = 256,
    parameter int MOD_DEPTH  = 64,
    parameter int LFO_STEP   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [8:0]        wet_gain,
    input  logic                     bypass,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int N_W     = ADDR_W + 1;
    localparam int POS_MAX = MOD_DEPTH * 256;
    // Wide enough to hold pos + LFO_STEP without wrapping before the clamp.
    localparam int POS_W   = $clog2(POS_MAX + LFO_STEP + 2);
    localparam int M_W     = DATA_W + 10;

    localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] STEP    = POS_W'(LFO_STEP);
    localparam logic [N_W-1:0]   N_FULL  = N_W'(DEPTH);
    localparam logic [N_W-1:0]   D_BASE  = N_W'(BASE_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TAPA,
`ifdef CHORUS_INTERP_EN
        S_TAPB,
`endif
        S_MIX
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [N_W-1:0]           n_q, n_d;
    logic [POS_W-1:0]         pos_q, pos_d;
    logic                     dir_q, dir_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic [8:0]               g_q, g_d;
    logic                     byp_q, byp_d;
    logic [ADDR_W-1:0]        addr_a_q, addr_a_d;
    logic                     ok_a_q, ok_a_d;
`ifdef CHORUS_INTERP_EN
    localparam int Y_W = DATA_W + 9;
    logic [ADDR_W-1:0]        addr_b_q, addr_b_d;
    logic                     ok_b_q, ok_b_d;
    logic [7:0]               frac_q, frac_d;
    logic signed [DATA_W-1:0] sa_q, sa_d;
`endif
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     mem_we;

    logic [N_W-1:0]           delay;
    logic signed [DATA_W-1:0] tap_y;
    logic [8:0]               g_inv;
    logic signed [M_W-1:0]    mix;
    logic signed [DATA_W-1:0] mix_out;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Integer part of the LFO position sets the tap delay.
    assign delay = D_BASE + N_W'(pos_q >> 8);

    // The tap value is formed in the cycle the last tap arrives from RAM, so
    // out_data/out_valid are registered on entry to MIX and line up with it.
`ifdef CHORUS_INTERP_EN
    logic signed [DATA_W-1:0] sb;
    logic signed [Y_W-1:0]    diff, prod;
    always_comb begin
        sb    = ok_b_q ? rd_data : '0;
        diff  = Y_W'(sb) - Y_W'(sa_q);
        prod  = diff * Y_W'($signed({1'b0, frac_q}));
        tap_y = DATA_W'(Y_W'(sa_q) + (prod >>> 8));
    end
`else
    assign tap_y = ok_a_q ? rd_data : '0;
`endif

    // Convex combination of dry and wet: the result always fits DATA_W.
    assign g_inv   = 9'd256 - g_q;
    assign mix     = M_W'(x_q) * M_W'($signed({1'b0, g_inv}))
                   + M_W'(tap_y) * M_W'($signed({1'b0, g_q}));
    assign mix_out = DATA_W'(mix >>> 8);

    // NOTE: the delay line has no reset; stale contents are masked by the
    // tap-valid flags derived from the sample counter instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= x_q;
        end
        rd_data <= mem[rd_addr];
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            n_q         <= '0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            x_q         <= '0;
            g_q         <= '0;
            byp_q       <= 1'b0;
            addr_a_q    <= '0;
            ok_a_q      <= 1'b0;
`ifdef CHORUS_INTERP_EN
            addr_b_q    <= '0;
            ok_b_q      <= 1'b0;
            frac_q      <= '0;
            sa_q        <= '0;
`endif
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            n_q         <= n_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            x_q         <= x_d;
            g_q         <= g_d;
            byp_q       <= byp_d;
            addr_a_q    <= addr_a_d;
            ok_a_q      <= ok_a_d;
`ifdef CHORUS_INTERP_EN
            addr_b_q    <= addr_b_d;
            ok_b_q      <= ok_b_d;
            frac_q      <= frac_d;
            sa_q        <= sa_d;
`endif
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path
        // through the case statement can infer a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        n_d         = n_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        x_d         = x_q;
        g_d         = g_q;
        byp_d       = byp_q;
        addr_a_d    = addr_a_q;
        ok_a_d      = ok_a_q;
`ifdef CHORUS_INTERP_EN
        addr_b_d    = addr_b_q;
        ok_b_d      = ok_b_q;
        frac_d      = frac_q;
        sa_d        = sa_q;
`endif
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        rd_addr     = addr_a_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d      = in_data;
                    g_d      = (wet_gain > 9'd256) ? 9'd256 : wet_gain;
                    byp_d    = bypass;
                    addr_a_d = wr_ptr_q - delay[ADDR_W-1:0];
                    // A tap older than the first sample since reset reads 0.
                    ok_a_d   = (n_q >= delay);
`ifdef CHORUS_INTERP_EN
                    addr_b_d = wr_ptr_q - delay[ADDR_W-1:0] - ADDR_W'(1);
                    ok_b_d   = (n_q > delay);
                    frac_d   = pos_q[7:0];
`endif
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                rd_addr = addr_a_q;
                state_d = S_TAPA;
            end
`ifdef CHORUS_INTERP_EN
            S_TAPA: begin
                sa_d    = ok_a_q ? rd_data : '0;
                rd_addr = addr_b_q;
                state_d = S_TAPB;
            end
            S_TAPB: begin
                out_data_d  = byp_q ? x_q : mix_out;
                out_valid_d = 1'b1;
                state_d     = S_MIX;
            end
`else
            S_TAPA: begin
                out_data_d  = byp_q ? x_q : mix_out;
                out_valid_d = 1'b1;
                state_d     = S_MIX;
            end
`endif
            S_MIX: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                n_d      = (n_q == N_FULL) ? n_q : n_q + N_W'(1);
                // Triangle LFO, advanced after use so sample 0 sees pos = 0.
                if (!dir_q) begin
                    if (pos_q + STEP >= POS_TOP) begin
                        pos_d = POS_TOP;
                        dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q + STEP;
                    end
                end else begin
                    if (pos_q <= STEP) begin
                        pos_d = '0;
                        dir_d = 1'b0;
                    end else begin
                        pos_d = pos_q - STEP;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
